// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back data select and a four-beat
// sequencer that turns one 128-bit vector load into four 32-bit register writes.
module mem_wb_stage (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_stall,
    input  logic         i_flush,
    input  logic [31:0]  i_pc,
    input  logic [31:0]  i_read_data,
    input  logic [31:0]  i_alu_result,
    input  logic [127:0] i_wd3_128,
    input  logic [4:0]   i_write_reg,
    input  logic         i_reg_write,
    input  logic         i_mem_to_reg,
    input  logic         i_vec128,
    output logic [31:0]  o_wb_pc,
    output logic [31:0]  o_wb_write_data,
    output logic [4:0]   o_wb_write_reg,
    output logic         o_wb_reg_write,
    output logic         o_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        VEC  = 1'b1
    } state_t;

    state_t       r_state, w_state_next;
    logic [1:0]   r_cnt, w_cnt_next;
    logic [127:0] r_buf, w_buf_next;
    logic [31:0]  r_wb_pc, w_wb_pc_next;
    logic [31:0]  r_wb_data, w_wb_data_next;
    logic [4:0]   r_wb_reg, w_wb_reg_next;
    logic         r_wb_we, w_wb_we_next;

    logic [31:0]  w_buf_word [4];
    logic [1:0]   w_cnt_inc;
    logic         w_busy;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf_word
            assign w_buf_word[gi] = r_buf[32*gi +: 32];
        end
    endgenerate

    assign w_busy    = (r_state == VEC) && (r_cnt != 2'd3);
    assign w_cnt_inc = r_cnt + 2'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_buf     <= '0;
            r_wb_pc   <= '0;
            r_wb_data <= '0;
            r_wb_reg  <= '0;
            r_wb_we   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_buf     <= w_buf_next;
            r_wb_pc   <= w_wb_pc_next;
            r_wb_data <= w_wb_data_next;
            r_wb_reg  <= w_wb_reg_next;
            r_wb_we   <= w_wb_we_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_buf_next     = r_buf;
        w_wb_pc_next   = r_wb_pc;
        w_wb_data_next = r_wb_data;
        w_wb_reg_next  = r_wb_reg;
        w_wb_we_next   = r_wb_we;

        if (i_flush) begin
            w_state_next   = IDLE;
            w_cnt_next     = 2'd0;
            w_wb_pc_next   = '0;
            w_wb_data_next = '0;
            w_wb_reg_next  = '0;
            w_wb_we_next   = 1'b0;
        end else if (i_stall) begin
            // everything holds; the repeated beat rewrites the same register
        end else if (w_busy) begin
            w_cnt_next     = w_cnt_inc;
            w_wb_data_next = w_buf_word[w_cnt_inc];
            w_wb_reg_next  = r_wb_reg + 5'd1;
        end else if (i_vec128 && i_reg_write) begin
            w_state_next   = VEC;
            w_cnt_next     = 2'd0;
            w_buf_next     = i_wd3_128;
            w_wb_pc_next   = i_pc;
            w_wb_data_next = i_wd3_128[31:0];
            w_wb_reg_next  = i_write_reg;
            w_wb_we_next   = 1'b1;
        end else begin
            w_state_next   = IDLE;
            w_cnt_next     = 2'd0;
            w_wb_pc_next   = i_pc;
            w_wb_data_next = i_mem_to_reg ? i_read_data : i_alu_result;
            w_wb_reg_next  = i_write_reg;
            w_wb_we_next   = i_reg_write;
        end
    end

    // r0 is hard-wired zero, so any write addressed to it is suppressed
    assign o_wb_reg_write  = r_wb_we && (r_wb_reg != 5'd0);
    assign o_wb_pc         = r_wb_pc;
    assign o_wb_write_data = r_wb_data;
    assign o_wb_write_reg  = r_wb_reg;
    assign o_busy          = w_busy;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed checks of mem_wb_stage against a queue-based model
// of pending write-back beats.
module tb_mem_wb_stage;

    logic         clk;
    logic         rst_n;
    logic         stall, flush;
    logic [31:0]  pc, read_data, alu_result;
    logic [127:0] wd3_128;
    logic [4:0]   write_reg;
    logic         reg_write, mem_to_reg, vec128;
    logic [31:0]  wb_pc, wb_data;
    logic [4:0]   wb_reg;
    logic         wb_we, busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rg;
        logic        we;
    } beat_t;

    beat_t cur;
    beat_t pend [$];

    mem_wb_stage dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_pc            (pc),
        .i_read_data     (read_data),
        .i_alu_result    (alu_result),
        .i_wd3_128       (wd3_128),
        .i_write_reg     (write_reg),
        .i_reg_write     (reg_write),
        .i_mem_to_reg    (mem_to_reg),
        .i_vec128        (vec128),
        .o_wb_pc         (wb_pc),
        .o_wb_write_data (wb_data),
        .o_wb_write_reg  (wb_reg),
        .o_wb_reg_write  (wb_we),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur = '{pc: 32'd0, data: 32'd0, rg: 5'd0, we: 1'b0};
        pend.delete();
    endtask

    // Expected outputs after one rising edge, from the sampled inputs
    task automatic model_edge();
        beat_t b;
        logic [4:0] r;
        if (flush) begin
            model_clear();
        end else if (stall) begin
            // hold
        end else if (pend.size() != 0) begin
            cur = pend.pop_front();
        end else if (vec128 && reg_write) begin
            cur = '{pc: pc, data: wd3_128[31:0], rg: write_reg, we: 1'b1};
            for (int k = 1; k < 4; k++) begin
                r = write_reg + 5'(k);
                b = '{pc: pc, data: wd3_128[32*k +: 32], rg: r, we: 1'b1};
                pend.push_back(b);
            end
        end else begin
            cur = '{pc: pc, data: (mem_to_reg ? read_data : alu_result),
                    rg: write_reg, we: reg_write};
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   wb_pc,          cur.pc);
        chk({tag, ".data"}, wb_data,        cur.data);
        chk({tag, ".reg"},  32'(wb_reg),    32'(cur.rg));
        chk({tag, ".we"},   32'(wb_we),     32'(cur.we && (cur.rg != 5'd0)));
        chk({tag, ".busy"}, 32'(busy),      32'(pend.size() != 0));
        $display("%-10s pc=%08h data=%08h r%0d we=%0d busy=%0d", tag, wb_pc, wb_data, wb_reg, wb_we, busy);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_idle();
        stall = 0; flush = 0; vec128 = 0; reg_write = 0; mem_to_reg = 0;
        pc = 0; read_data = 0; alu_result = 0; wd3_128 = '0; write_reg = 0;
    endtask

    task automatic set_vec(input logic [4:0] wr, input logic [127:0] d);
        set_idle();
        vec128 = 1; reg_write = 1; write_reg = wr; wd3_128 = d; pc = $urandom;
    endtask

    task automatic rand_data();
        pc = $urandom; read_data = $urandom; alu_result = $urandom;
        wd3_128 = {$urandom, $urandom, $urandom, $urandom};
        write_reg = 5'($urandom_range(0, 31));
        mem_to_reg = 1'($urandom); reg_write = ($urandom_range(0, 9) != 0);
    endtask

    task automatic rand_inputs();
        rand_data();
        vec128 = ($urandom_range(0, 9) < 3);
        stall  = ($urandom_range(0, 99) < 12);
        flush  = ($urandom_range(0, 99) < 5);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_clear();
        @(negedge clk);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a vector sequence
        set_vec(5'd3, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
        cycle("rst_b0");
        rand_data();
        cycle("rst_b1");
        #2 rst_n = 1'b0;
        #1 model_clear();
        check_all("rst_async");
        @(negedge clk);
        check_all("rst_hold");
        rst_n = 1'b1;
        set_idle();
        alu_result = 32'h12345678; write_reg = 5'd5; reg_write = 1; pc = 32'h100;
        cycle("rst_alu");

        // Scalar mux and r0 suppression
        set_idle();
        mem_to_reg = 1; read_data = 32'hDEADBEEF; alu_result = 32'h0BADF00D;
        write_reg = 5'd9; reg_write = 1; pc = 32'h104;
        cycle("ld_r9");
        write_reg = 5'd0;
        cycle("ld_r0");

        // Vector load with upstream inputs changing while busy
        set_vec(5'd8, 128'h44444444_33333333_22222222_11111111);
        cycle("vec_b0");
        for (int i = 1; i < 4; i++) begin
            rand_data();
            vec128 = 1'($urandom);
            cycle($sformatf("vec_b%0d", i));
        end

        // Register wrap-around
        set_vec(5'd30, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
        for (int i = 0; i < 4; i++) cycle($sformatf("wrap_b%0d", i));

        // Stall during beat 1, then flush during beat 2
        set_vec(5'd20, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
        cycle("sf_b0");
        set_idle();
        cycle("sf_b1");
        stall = 1;
        cycle("sf_st1");
        cycle("sf_st2");
        stall = 0;
        cycle("sf_b2");
        flush = 1; stall = 1;
        cycle("sf_flush");
        flush = 0; stall = 0;
        alu_result = 32'h55AA55AA; reg_write = 1; write_reg = 5'd7;
        cycle("sf_after");

        // Back-to-back vector loads
        set_vec(5'd4, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
        cycle("b2b_0");
        set_vec(5'd12, {32'hE4, 32'hE3, 32'hE2, 32'hE1});
        for (int i = 1; i < 8; i++) cycle($sformatf("b2b_%0d", i));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
